if_unit: RTL and testbench

Instruction fetch sequencer for the SISC processor. It fetches from instruction memory over a request/acknowledge handshake using the current program counter value, and holds the fetched word in the instruction register for decode/execute. When the instruction retires, it drives the program counter's write strobe and next-address select (PC+1 or branch target). It sits between the program counter, the instruction memory and the control/decode stage.

---
 rtl/if_unit.sv | 137 +++++++++++++
 tb/tb_if_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_unit.sv
// if_unit: instruction fetch sequencer (ISSUE -> WAIT -> HOLD -> UPD).
// Latency: request 1 cycle after ISSUE; ir_valid 1 cycle after im_ack; 4 cycles/instr at best.
// Backpressure: holds the fetched word in ir until ir_done; a fetch with no ack is abandoned after TIMEOUT cycles and reissued.
//
// Ports:
//   clk, if_rst          clock and synchronous active-high reset
//   pc_out               current program counter value (fetch address source)
//   pc_write, pc_sel     one-cycle PC load strobe; select 0 = PC+1, 1 = branch target
//   im_addr, im_req      registered instruction memory request
//   im_ack, im_data      memory acknowledge with same-cycle instruction word
//   ir, ir_valid         instruction register and its "fetched, unretired" flag
//   ir_done, br_taken    retire strobe from decode/execute and branch decision
//   if_err               sticky fetch-timeout flag
//   fetch_cnt            count of accepted fetches, wraps at 16 bits
module if_unit #(
  parameter int IW      = 32,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          if_rst,
  input  logic [AW-1:0] pc_out,
  output logic          pc_write,
  output logic          pc_sel,
  output logic [AW-1:0] im_addr,
  output logic          im_req,
  input  logic          im_ack,
  input  logic [IW-1:0] im_data,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_done,
  input  logic          br_taken,
  output logic          if_err,
  output logic [15:0]   fetch_cnt
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    UPD   = 2'd3
  } state_t;

  // Last WAIT count value before the fetch is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       wait_expired;

  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (if_rst) begin
      state <= ISSUE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (im_ack) begin
          state_nxt = HOLD;
        end else if (wait_expired) begin
          state_nxt = ISSUE;
        end
      end
      HOLD: begin
        if (ir_done) begin
          state_nxt = UPD;
        end
      end
      UPD:     state_nxt = ISSUE;
      default: state_nxt = ISSUE;
    endcase
  end

  // Registered outputs and datapath. Inputs not relevant to the current
  // state (stray acks, stray retires) simply fall through untouched.
  always_ff @(posedge clk) begin
    if (if_rst) begin
      pc_write  <= 1'b0;
      pc_sel    <= 1'b0;
      im_addr   <= '0;
      im_req    <= 1'b0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      if_err    <= 1'b0;
      fetch_cnt <= 16'd0;
      wait_cnt  <= 8'd0;
    end else begin
      case (state)
        ISSUE: begin
          im_addr  <= pc_out;
          im_req   <= 1'b1;
          wait_cnt <= 8'd0;
        end
        WAIT: begin
          if (im_ack) begin
            ir        <= im_data;
            ir_valid  <= 1'b1;
            im_req    <= 1'b0;
            fetch_cnt <= fetch_cnt + 16'd1;
          end else if (wait_expired) begin
            // PC has not moved, so the reissue targets the same address.
            im_req <= 1'b0;
            if_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (ir_done) begin
            pc_write <= 1'b1;
            pc_sel   <= br_taken;
            ir_valid <= 1'b0;
          end
        end
        UPD: begin
          // PC loads at the end of this cycle; ISSUE then sees the new value.
          pc_write <= 1'b0;
          pc_sel   <= 1'b0;
        end
        default: begin
          pc_write <= 1'b0;
          pc_sel   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_unit.sv
// tb_if_unit: directed bench for if_unit with a small program counter model.
// Main instance uses TIMEOUT=15; a second instance with TIMEOUT=4 never sees an ack.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_if_unit;

  localparam int IW = 32;
  localparam int AW = 16;
  localparam logic [AW-1:0] BR_ADDR = 16'h0040;

  logic          clk = 1'b0;
  logic          if_rst;
  logic [AW-1:0] pc_out;
  logic          pc_write;
  logic          pc_sel;
  logic [AW-1:0] im_addr;
  logic          im_req;
  logic          im_ack;
  logic [IW-1:0] im_data;
  logic [IW-1:0] ir;
  logic          ir_valid;
  logic          ir_done;
  logic          br_taken;
  logic          if_err;
  logic [15:0]   fetch_cnt;

  // Timeout instance signals.
  logic          rst_t;
  logic [AW-1:0] pc_t;
  logic          pc_write_t;
  logic          pc_sel_t;
  logic [AW-1:0] im_addr_t;
  logic          im_req_t;
  logic          ack_t;
  logic [IW-1:0] ir_t;
  logic          ir_valid_t;
  logic          done_t;
  logic          if_err_t;
  logic [15:0]   fetch_cnt_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_unit #(.IW(IW), .AW(AW), .TIMEOUT(15)) dut (
    .clk(clk), .if_rst(if_rst), .pc_out(pc_out), .pc_write(pc_write), .pc_sel(pc_sel),
    .im_addr(im_addr), .im_req(im_req), .im_ack(im_ack), .im_data(im_data),
    .ir(ir), .ir_valid(ir_valid), .ir_done(ir_done), .br_taken(br_taken),
    .if_err(if_err), .fetch_cnt(fetch_cnt)
  );

  if_unit #(.IW(IW), .AW(AW), .TIMEOUT(4)) dut_t (
    .clk(clk), .if_rst(rst_t), .pc_out(pc_t), .pc_write(pc_write_t), .pc_sel(pc_sel_t),
    .im_addr(im_addr_t), .im_req(im_req_t), .im_ack(ack_t), .im_data(im_data),
    .ir(ir_t), .ir_valid(ir_valid_t), .ir_done(done_t), .br_taken(1'b0),
    .if_err(if_err_t), .fetch_cnt(fetch_cnt_t)
  );

  // Program counter model: loads PC+1 or the branch target on pc_write.
  always_ff @(posedge clk) begin
    if (if_rst) begin
      pc_out <= '0;
    end else if (pc_write) begin
      pc_out <= pc_sel ? BR_ADDR : pc_out + 16'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    if_rst   = 1'b1;
    im_ack   = 1'b0;
    im_data  = '0;
    ir_done  = 1'b0;
    br_taken = 1'b0;
    rst_t    = 1'b1;
    pc_t     = 16'h0077;
    ack_t    = 1'b0;
    done_t   = 1'b0;

    tick(); tick();
    // Reset values
    check("rst_pc_write", 32'(pc_write), 32'd0);
    check("rst_pc_sel", 32'(pc_sel), 32'd0);
    check("rst_im_req", 32'(im_req), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_if_err", 32'(if_err), 32'd0);
    check("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);

    // Sequential fetch from address 0
    if_rst = 1'b0;
    tick();                                  // ISSUE done, now WAIT
    check("seq_req", 32'(im_req), 32'd1);
    check("seq_addr", 32'(im_addr), 32'h0000);
    im_ack = 1'b1; im_data = 32'h12345678;
    tick();                                  // now HOLD
    im_ack = 1'b0;
    check("seq_ir", ir, 32'h12345678);
    check("seq_ir_valid", 32'(ir_valid), 32'd1);
    check("seq_req_drop", 32'(im_req), 32'd0);
    check("seq_cnt", 32'(fetch_cnt), 32'd1);
    ir_done = 1'b1; br_taken = 1'b0;
    tick();                                  // now UPD
    ir_done = 1'b0;
    check("seq_pc_write", 32'(pc_write), 32'd1);
    check("seq_pc_sel", 32'(pc_sel), 32'd0);
    check("seq_ir_valid_clr", 32'(ir_valid), 32'd0);
    check("seq_wr_vs_req", 32'(im_req), 32'd0);
    tick();                                  // now ISSUE
    check("seq_pc_write_pulse", 32'(pc_write), 32'd0);
    check("seq_ir_hold", ir, 32'h12345678);
    tick();                                  // now WAIT
    check("seq_next_req", 32'(im_req), 32'd1);
    check("seq_next_addr", 32'(im_addr), 32'h0001);

    // Branch
    im_ack = 1'b1; im_data = 32'hA5A50001;
    tick();
    im_ack = 1'b0;
    check("br_ir", ir, 32'hA5A50001);
    check("br_cnt", 32'(fetch_cnt), 32'd2);
    ir_done = 1'b1; br_taken = 1'b1;
    tick();
    ir_done = 1'b0; br_taken = 1'b0;
    check("br_pc_write", 32'(pc_write), 32'd1);
    check("br_pc_sel", 32'(pc_sel), 32'd1);
    tick();
    check("br_pc_write_pulse", 32'(pc_write), 32'd0);
    check("br_pc_sel_clr", 32'(pc_sel), 32'd0);
    tick();
    check("br_req", 32'(im_req), 32'd1);
    check("br_addr", 32'(im_addr), 32'h0040);

    // Slow memory: ack after 5 idle WAIT cycles
    for (int i = 0; i < 5; i++) begin
      check("slow_req", 32'(im_req), 32'd1);
      check("slow_addr", 32'(im_addr), 32'h0040);
      tick();
    end
    check("slow_req_last", 32'(im_req), 32'd1);
    im_ack = 1'b1; im_data = 32'hDEADBEEF;
    tick();                                  // now HOLD
    check("slow_ir", ir, 32'hDEADBEEF);
    check("slow_no_err", 32'(if_err), 32'd0);
    check("slow_cnt", 32'(fetch_cnt), 32'd3);

    // Stray ack in HOLD must not reload ir
    im_data = 32'h11111111;
    tick();
    im_ack = 1'b0;
    check("stray_hold_ir", ir, 32'hDEADBEEF);
    check("stray_hold_cnt", 32'(fetch_cnt), 32'd3);
    check("stray_hold_valid", 32'(ir_valid), 32'd1);
    ir_done = 1'b1;
    tick();                                  // now UPD
    check("stray_ret_pc_write", 32'(pc_write), 32'd1);
    im_ack = 1'b1;                           // stray ack and ir_done in UPD
    tick();                                  // now ISSUE
    check("stray_upd_pc_write", 32'(pc_write), 32'd0);
    tick();                                  // stray in ISSUE, now WAIT
    im_ack = 1'b0; ir_done = 1'b0;
    check("stray_issue_pc_write", 32'(pc_write), 32'd0);
    check("stray_issue_ir", ir, 32'hDEADBEEF);
    check("stray_issue_req", 32'(im_req), 32'd1);
    check("stray_issue_addr", 32'(im_addr), 32'h0041);
    ir_done = 1'b1; br_taken = 1'b1;         // stray retire in WAIT
    tick();
    ir_done = 1'b0; br_taken = 1'b0;
    check("stray_wait_pc_write", 32'(pc_write), 32'd0);
    check("stray_wait_req", 32'(im_req), 32'd1);

    // Reset in WAIT with a pending ack
    if_rst = 1'b1; im_ack = 1'b1; im_data = 32'h22222222;
    tick();
    if_rst = 1'b0; im_ack = 1'b0;
    check("mrst_req", 32'(im_req), 32'd0);
    check("mrst_addr", 32'(im_addr), 32'd0);
    check("mrst_ir", ir, 32'd0);
    check("mrst_ir_valid", 32'(ir_valid), 32'd0);
    check("mrst_cnt", 32'(fetch_cnt), 32'd0);
    check("mrst_pc_write", 32'(pc_write), 32'd0);
    check("mrst_pc_sel", 32'(pc_sel), 32'd0);
    tick();
    check("mrst_req_again", 32'(im_req), 32'd1);
    check("mrst_addr_again", 32'(im_addr), 32'h0000);

    // Counter wrap: preload 0xFFFF in HOLD, then one more fetch
    im_ack = 1'b1; im_data = 32'h0BADF00D;
    tick();
    im_ack = 1'b0;
    check("wrap_cnt_pre", 32'(fetch_cnt), 32'd1);
    force dut.fetch_cnt = 16'hFFFF;
    tick();
    release dut.fetch_cnt;
    tick();
    check("wrap_cnt_loaded", 32'(fetch_cnt), 32'hFFFF);
    ir_done = 1'b1;
    tick();
    ir_done = 1'b0;
    tick(); tick();                          // UPD, ISSUE -> WAIT
    check("wrap_req", 32'(im_req), 32'd1);
    im_ack = 1'b1; im_data = 32'hCAFE0000;
    tick();
    im_ack = 1'b0;
    check("wrap_cnt", 32'(fetch_cnt), 32'h0000);
    check("wrap_ir", ir, 32'hCAFE0000);

    // Timeout on the TIMEOUT=4 instance
    rst_t = 1'b0;
    tick();                                  // ISSUE done, now WAIT
    for (int i = 0; i < 4; i++) begin
      check("to_req_held", 32'(im_req_t), 32'd1);
      check("to_addr", 32'(im_addr_t), 32'h0077);
      check("to_no_err_yet", 32'(if_err_t), 32'd0);
      tick();
    end
    check("to_req_drop", 32'(im_req_t), 32'd0);
    check("to_err", 32'(if_err_t), 32'd1);
    check("to_cnt", 32'(fetch_cnt_t), 32'd0);
    tick();
    check("to_reissue_req", 32'(im_req_t), 32'd1);
    check("to_reissue_addr", 32'(im_addr_t), 32'h0077);
    check("to_err_sticky", 32'(if_err_t), 32'd1);
    check("to_no_pc_write", 32'(pc_write_t), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
